word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 19 +
 rtl/mux32.sv | 13 +
 rtl/word_serializer.sv | 134 +++++++++++++
 tb/tb_word_serializer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared constants and the state type for the 32-bit word serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Optional feature macro: WORD_SERIALIZER_PARITY_EN adds the PARITY state.
package word_serializer_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef WORD_SERIALIZER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/mux32.sv
// 32:1 single-bit selector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: data_i (32-bit word), sel_i (5-bit index), bit_o (selected bit).
module mux32 (
    input  logic [31:0] data_i,
    input  logic [4:0]  sel_i,
    output logic        bit_o
);

    assign bit_o = data_i[sel_i];

endmodule

// File: rtl/word_serializer.sv
// Serializes 32-bit words into one bit per beat, LSB or MSB first.
// Latency: first bit valid the cycle after the word is accepted.
// Backpressure: out_ready low holds the current beat; in_ready only in IDLE or on the last beat with out_ready.
//
// Ports:
//   clk, rst (async active-low)
//   in_valid / in_ready / in_data[31:0]       : parallel word input handshake
//   out_valid / out_ready / out_bit / out_last : serial beat output handshake
//   sel[4:0]                                   : index of the bit being presented
// Optional feature macro: WORD_SERIALIZER_PARITY_EN appends one even-parity beat per word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic [IDX_W-1:0]  sel
);

    localparam logic [IDX_W-1:0] FIRST_IDX = (MSB_FIRST != 0) ? 5'd31 : 5'd0;
    localparam logic [IDX_W-1:0] LAST_IDX  = (MSB_FIRST != 0) ? 5'd0  : 5'd31;
    localparam logic [IDX_W-1:0] IDX_ONE   = 5'd1;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic [IDX_W-1:0]   sel_q,   sel_d;

    logic               mux_bit;
    logic               final_data;
    logic               last_beat;
    logic               ready_c;

    mux32 u_mux32 (
        .data_i (word_q),
        .sel_i  (sel_q),
        .bit_o  (mux_bit)
    );

    assign final_data = (sel_q == LAST_IDX);
    assign sel        = sel_q;
    // Reset must hold in_ready low even though the state register reads IDLE.
    assign in_ready   = ready_c & rst;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        sel_d     = sel_q;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        ready_c   = 1'b0;
        last_beat = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    sel_d   = FIRST_IDX;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = mux_bit;
`ifdef WORD_SERIALIZER_PARITY_EN
                // The parity beat closes the word, so the final data beat is not last.
                if (out_ready) begin
                    if (final_data) begin
                        sel_d   = '0;
                        state_d = PARITY;
                    end else begin
                        sel_d = (MSB_FIRST != 0) ? (sel_q - IDX_ONE) : (sel_q + IDX_ONE);
                    end
                end
`else
                out_last  = final_data;
                last_beat = final_data;
                if (out_ready && !final_data) begin
                    sel_d = (MSB_FIRST != 0) ? (sel_q - IDX_ONE) : (sel_q + IDX_ONE);
                end
`endif
            end

`ifdef WORD_SERIALIZER_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                out_bit   = ^word_q;
                out_last  = 1'b1;
                last_beat = 1'b1;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        // Closing beat consumed: take the next word in the same cycle so
        // consecutive words stream without an idle gap.
        if (last_beat && out_ready) begin
            ready_c = 1'b1;
            if (in_valid) begin
                word_d  = in_data;
                sel_d   = FIRST_IDX;
                state_d = SHIFT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first instance share stimulus;
// a beat-list scoreboard predicts every presented beat and in_ready.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 33 : 32;

    typedef struct packed {
        logic       last;
        logic [4:0] idx;
        logic       val;
    } beat_t;

    typedef struct packed {
        beat_t l;
        beat_t m;
    } pair_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        ir0, ov0, ob0, ol0;
    logic [4:0]  sel0;
    logic        ir1, ov1, ob1, ol1;
    logic [4:0]  sel1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    pair_t       q[$];

    word_serializer #(.MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_bit(ob0), .out_last(ol0), .sel(sel0)
    );

    word_serializer #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_bit(ob1), .out_last(ol1), .sel(sel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Scoreboard: each accepted word expands into its full list of beats.
    always @(negedge clk) begin
        logic       exp_rdy;
        logic       a_ir, a_ov, a_ob, a_ol;
        logic [4:0] a_sel;
        beat_t      e;
        pair_t      p;
        if (rst === 1'b1) begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
            for (int d = 0; d < 2; d++) begin
                a_ir  = (d == 0) ? ir0  : ir1;
                a_ov  = (d == 0) ? ov0  : ov1;
                a_ob  = (d == 0) ? ob0  : ob1;
                a_ol  = (d == 0) ? ol0  : ol1;
                a_sel = (d == 0) ? sel0 : sel1;
                n_cmp++;
                if (a_ir !== exp_rdy) begin
                    n_err++;
                    $display("FAIL mon_in_ready dut%0d t=%0t got %b want %b", d, $time, a_ir, exp_rdy);
                end
                n_cmp++;
                if (a_ov !== (q.size() != 0)) begin
                    n_err++;
                    $display("FAIL mon_out_valid dut%0d t=%0t got %b want %b", d, $time, a_ov, q.size() != 0);
                end
                if (q.size() != 0) begin
                    e = (d == 0) ? q[0].l : q[0].m;
                    n_cmp++;
                    if (a_ob !== e.val || a_sel !== e.idx || a_ol !== e.last) begin
                        n_err++;
                        $display("FAIL mon_beat dut%0d t=%0t got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                                 d, $time, a_ob, a_sel, a_ol, e.val, e.idx, e.last);
                    end
                end else begin
                    n_cmp++;
                    if (a_ol !== 1'b0) begin
                        n_err++;
                        $display("FAIL mon_idle_last dut%0d t=%0t got %b want 0", d, $time, a_ol);
                    end
                end
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                for (int k = 0; k < 32; k++) begin
                    p.l.last = (k == 31) && !PAR;
                    p.l.idx  = k[4:0];
                    p.l.val  = in_data[k];
                    p.m.last = (k == 31) && !PAR;
                    p.m.idx  = 5'(31 - k);
                    p.m.val  = in_data[31 - k];
                    q.push_back(p);
                end
`ifdef WORD_SERIALIZER_PARITY_EN
                p.l.last = 1'b1;
                p.l.idx  = 5'd0;
                p.l.val  = ^in_data;
                p.m      = p.l;
                q.push_back(p);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic push_word(input logic [31:0] w, input bit keep, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && waited < 300) begin
            @(negedge clk);
            acc = ir0;
            waited++;
            tick();
        end
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL push_timeout word=%h got no accept want accept within 300 cycles", w);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 1000) begin
            tick();
            c++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout got %0d beats pending want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if ({ir0, ov0, ob0, ol0, sel0, ir1, ov1, ob1, ol1, sel1} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want all zero",
                     {ir0, ov0, ob0, ol0, sel0, ir1, ov1, ob1, ol1, sel1});
        end
        rdy_mode = 0;
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got ir=%b%b ov=%b%b want ir=11 ov=00", ir0, ir1, ov0, ov1);
        end
        tick();
    endtask

    task automatic test_lsb_one();
        int w;
        rdy_mode = 0;
        push_word(32'h0000_0001, 1'b0, w);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ob0 !== (k == 0) || sel0 !== 5'(k) || ol0 !== ((k == 31) && !PAR)) begin
                n_err++;
                $display("FAIL lsb_one beat %0d got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                         k, ob0, sel0, ol0, k == 0, k, (k == 31) && !PAR);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_msb_one();
        int w;
        rdy_mode = 0;
        push_word(32'h8000_0000, 1'b0, w);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ob1 !== (k == 0) || sel1 !== 5'(31 - k) || ol1 !== ((k == 31) && !PAR)) begin
                n_err++;
                $display("FAIL msb_one beat %0d got bit=%b sel=%0d last=%b want bit=%b sel=%0d last=%b",
                         k, ob1, sel1, ol1, k == 0, 31 - k, (k == 31) && !PAR);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_toggle();
        logic [31:0] got;
        int n, c, w;
        got = '0; n = 0; c = 0;
        rdy_mode = 1;
        push_word(32'hA5A5_A5A5, 1'b0, w);
        while (n < NB && c < 200) begin
            @(negedge clk);
            if (ov0 && out_ready) begin
                if (n < 32) got[n] = ob0;
                n++;
            end
            c++;
            tick();
        end
        n_cmp++;
        if (got !== 32'hA5A5_A5A5 || n != NB) begin
            n_err++;
            $display("FAIL toggle_seq got %h (%0d beats) want a5a5a5a5 (%0d beats)", got, n, NB);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w1, w2;
        rdy_mode = 0;
        push_word(32'hFFFF_FFFF, 1'b1, w1);
        push_word(32'h0000_0000, 1'b0, w2);
        n_cmp++;
        if (w2 != NB) begin
            n_err++;
            $display("FAIL b2b_gap got second accept after %0d cycles want %0d", w2, NB);
        end
        @(negedge clk);
        n_cmp++;
        if (ov0 !== 1'b1 || sel0 !== 5'd0 || ob0 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first got ov=%b sel=%0d bit=%b want ov=1 sel=0 bit=0", ov0, sel0, ob0);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int w;
        rdy_mode = 0;
        push_word($urandom | 32'h1, 1'b0, w);
        repeat (10) tick();
        n_cmp++;
        if (sel0 !== 5'd10) begin
            n_err++;
            $display("FAIL mid_beat10 got sel=%0d want 10", sel0);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({ir0, ov0, ob0, ol0, sel0, ir1, ov1, ob1, ol1, sel1} !== 18'h0) begin
            n_err++;
            $display("FAIL mid_reset_outputs got %b want all zero",
                     {ir0, ov0, ob0, ol0, sel0, ir1, ov1, ob1, ol1, sel1});
        end
        q.delete();
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ir0 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_release_ready got %b want 1", ir0);
        end
        tick();
        push_word(32'h0000_0100, 1'b0, w);
        @(negedge clk);
        n_cmp++;
        if (ov0 !== 1'b1 || sel0 !== 5'd0 || ob0 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_new_word got ov=%b sel=%0d bit=%b want ov=1 sel=0 bit=0", ov0, sel0, ob0);
        end
        drain();
    endtask

    task automatic test_random();
        int w;
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) begin
            push_word($urandom, 1'b0, w);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
    endtask

`ifdef WORD_SERIALIZER_PARITY_EN
    task automatic test_parity();
        int w;
        logic [31:0] words [2];
        logic        par   [2];
        words[0] = 32'h0000_0007; par[0] = 1'b1;
        words[1] = 32'h0000_0003; par[1] = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 2; i++) begin
            push_word(words[i], 1'b0, w);
            repeat (32) tick();
            @(negedge clk);
            n_cmp++;
            if (ob0 !== par[i] || ol0 !== 1'b1 || sel0 !== 5'd0 || ob1 !== par[i] || ol1 !== 1'b1) begin
                n_err++;
                $display("FAIL parity_beat word=%h got bit=%b/%b last=%b/%b sel=%0d want bit=%b last=1 sel=0",
                         words[i], ob0, ob1, ol0, ol1, sel0, par[i]);
            end
            drain();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_one();
        test_msb_one();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef WORD_SERIALIZER_PARITY_EN
        test_parity();
`endif
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
